// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 signed multiplier.
// Holds the FSM state encoding and the X/A/B register control bundle.
package mult_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } state_t;

    typedef struct packed {
        logic ld_b;
        logic clr_xa;
        logic ld_xa;
        logic shift;
    } xab_ctrl_t;

endpackage

// File: rtl/shift_reg_xab.sv
// X/A/B register chain of the shift-add multiplier.
// Supports load-B, clear-XA, load-XA-from-sum and arithmetic right shift.
module shift_reg_xab
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  xab_ctrl_t        ctrl,
    input  logic [WIDTH-1:0] sw,
    input  logic [WIDTH:0]   sum,
    output logic             x,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    // X and A: clear, take the 9-bit sum, or shift right with X held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= 1'b0;
            a <= '0;
        end else if (ctrl.clr_xa) begin
            x <= 1'b0;
            a <= '0;
        end else if (ctrl.ld_xa) begin
            x <= sum[WIDTH];
            a <= sum[WIDTH-1:0];
        end else if (ctrl.shift) begin
            a <= {x, a[WIDTH-1:1]};
        end
    end

    // B: load the multiplier, or take A[0] in at the top on a shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b <= '0;
        end else if (ctrl.ld_b) begin
            b <= sw;
        end else if (ctrl.shift) begin
            b <= {a[0], b[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the 8x8 signed shift-add multiplier.
// Drives the external 9-bit add/sub stage and owns the X/A/B chain.
module mult_seq_ctrl
    import mult_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] Sw,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_fn,
    input  logic [WIDTH:0]   add_s,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Done
);

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] m_nxt;
    xab_ctrl_t        ctrl;

    logic             x;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    shift_reg_xab u_xab (
        .clk   (Clk),
        .rst_n (Reset_n),
        .ctrl  (ctrl),
        .sw    (Sw),
        .sum   (add_s),
        .x     (x),
        .a     (a),
        .b     (b)
    );

    // State, iteration counter and latched multiplicand.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            m     <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            m     <= m_nxt;
        end
    end

    // Next state, register-chain controls and adder function select.
    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        m_nxt   = m;
        ctrl    = '0;
        add_fn  = 1'b0;
        Done    = 1'b0;
        case (state)
            IDLE: begin
                if (Run) begin
                    m_nxt       = Sw;
                    cnt_nxt     = '0;
                    ctrl.clr_xa = 1'b1;
                    nxt         = ADD;
                end else if (ClearA_LoadB) begin
                    ctrl.clr_xa = 1'b1;
                    ctrl.ld_b   = 1'b1;
                end
            end
            ADD: begin
                add_fn     = (cnt == CNT_LAST);
                ctrl.ld_xa = b[0];
                nxt        = SHIFT;
            end
            SHIFT: begin
                ctrl.shift = 1'b1;
                if (cnt == CNT_LAST) begin
                    nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    nxt     = ADD;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (!Run) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign add_a = a;
    assign add_b = m;
    assign Aval  = a;
    assign Bval  = b;
    assign Xval  = x;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl closed around a 9-bit add/sub stage model.
// Expected products are queued at start and checked when Done rises.
module tb_mult_seq_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] Sw;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_fn;
    logic [8:0] add_s;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;
    logic       Done;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       x;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mult_seq_ctrl dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .Sw           (Sw),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_fn       (add_fn),
        .add_s        (add_s),
        .Aval         (Aval),
        .Bval         (Bval),
        .Xval         (Xval),
        .Done         (Done)
    );

    // 9-bit add/subtract stage with sign extension of both operands.
    assign add_s = add_fn
        ? ({add_a[7], add_a} - {add_b[7], add_b})
        : ({add_a[7], add_a} + {add_b[7], add_b});

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: on each rising Done, pop and compare {X,A,B}.
    initial begin
        logic dq;
        exp_t e;
        dq = 1'b0;
        forever begin
            @(negedge Clk);
            if (Reset_n && Done && !dq) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_prod"},
                          {15'd0, Xval, Aval, Bval},
                          {15'd0, e.x, e.a, e.b});
                end
            end
            dq = Done;
        end
    end

    task automatic mul(input string      nm,
                       input logic [7:0] b,
                       input logic [7:0] m,
                       input logic [7:0] ea,
                       input logic [7:0] eb,
                       input logic       ex,
                       input bit         both,
                       input bit         disturb,
                       input int         hold);
        exp_t e;
        int   n;
        int   fn_cnt;
        int   fn_at;
        int   drop;
        Sw           = b;
        ClearA_LoadB = 1'b1;
        @(posedge Clk);
        #1;
        ClearA_LoadB = 1'b0;
        check({nm, "_loadb"}, {23'd0, Xval, Aval, Bval},
              {23'd0, 1'b0, 8'h00, b});
        Sw           = m;
        Run          = 1'b1;
        ClearA_LoadB = both;
        e.name = nm;
        e.a    = ea;
        e.b    = eb;
        e.x    = ex;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        ClearA_LoadB = 1'b0;
        n      = 0;
        fn_cnt = 0;
        fn_at  = -1;
        while (!Done && n < 40) begin
            if (add_fn) begin
                fn_cnt++;
                fn_at = n;
            end
            if (disturb) begin
                ClearA_LoadB = n[0];
                Sw           = 8'hA5 ^ 8'(n);
            end
            @(posedge Clk);
            #1;
            n++;
        end
        ClearA_LoadB = 1'b0;
        check({nm, "_latency"}, n + 1, 17);
        check({nm, "_fn_count"}, fn_cnt, 1);
        check({nm, "_fn_cycle"}, fn_at, 14);
        drop = 0;
        repeat (hold) begin
            @(posedge Clk);
            #1;
            if (!Done) drop++;
        end
        if (hold > 0) check({nm, "_hold_done"}, drop, 0);
        Run = 1'b0;
        @(posedge Clk);
        #1;
        check({nm, "_idle"}, {31'd0, Done}, 32'd0);
    endtask

    initial begin
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        Sw           = 8'h00;
        Reset_n      = 1'b1;
        #1;
        Reset_n = 1'b0;
        #11;
        check("reset_state",
              {13'd0, Aval, Bval, Xval, Done, add_fn},
              32'd0);
        check("reset_addb", {24'd0, add_b}, 32'd0);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        mul("p3x7",    8'h03, 8'h07, 8'h00, 8'h15, 1'b0, 0, 0, 0);
        mul("n3x2",    8'hFD, 8'h02, 8'hFF, 8'hFA, 1'b1, 0, 0, 0);
        mul("n1xn1",   8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0, 0, 0, 0);
        mul("127xn128",8'h7F, 8'h80, 8'hC0, 8'h80, 1'b1, 0, 0, 0);
        mul("n128sq",  8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 0, 0, 0);
        mul("n128x5",  8'h80, 8'h05, 8'hFD, 8'h80, 1'b1, 0, 0, 0);
        mul("100x100", 8'h64, 8'h64, 8'h27, 8'h10, 1'b0, 0, 0, 0);
        mul("0x85",    8'h00, 8'h55, 8'h00, 8'h00, 1'b0, 0, 0, 0);
        mul("hold",    8'h05, 8'hF9, 8'hFF, 8'hDD, 1'b1, 0, 1, 40);
        mul("both",    8'h03, 8'h07, 8'h00, 8'h15, 1'b0, 1, 0, 0);

        // Abort a multiply in the SHIFT state with an async reset.
        Sw           = 8'hFF;
        ClearA_LoadB = 1'b1;
        @(posedge Clk);
        #1;
        ClearA_LoadB = 1'b0;
        Sw           = 8'h7F;
        Run          = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        check("pre_reset", {15'd0, Xval, Aval, Bval},
              {15'd0, 1'b0, 8'hBE, 8'hFF});
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_reset",
              {13'd0, Aval, Bval, Xval, Done, add_fn},
              32'd0);
        check("async_reset_addb", {24'd0, add_b}, 32'd0);
        Run = 1'b0;
        #3;
        Reset_n = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("post_reset_idle",
              {15'd0, Aval, Bval, Done},
              32'd0);

        repeat (3) @(posedge Clk);
        #1;
        check("queue_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
